// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared RV32F decode constants, issue-stage state encoding
//                and destination/source classification helpers.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

   // OP-FP funct5 codes (instr[31:27])
   localparam logic [4:0] F5_FADD   = 5'b00000;
   localparam logic [4:0] F5_FSUB   = 5'b00001;
   localparam logic [4:0] F5_FMUL   = 5'b00010;
   localparam logic [4:0] F5_FDIV   = 5'b00011;
   localparam logic [4:0] F5_FSGNJ  = 5'b00100;
   localparam logic [4:0] F5_FMINMX = 5'b00101;
   localparam logic [4:0] F5_FSQRT  = 5'b01011;
   localparam logic [4:0] F5_FCMP   = 5'b10100;
   localparam logic [4:0] F5_FCVTWS = 5'b11000;
   localparam logic [4:0] F5_FCVTSW = 5'b11010;
   localparam logic [4:0] F5_FMVXW  = 5'b11100;
   localparam logic [4:0] F5_FMVWX  = 5'b11110;

   // Major opcode bits [6:2] for OP-FP and the four fused multiply-add forms
   localparam logic [4:0] OPC_OPFP   = 5'b10100;
   localparam logic [4:0] OPC_FMADD  = 5'b10000;
   localparam logic [4:0] OPC_FMSUB  = 5'b10001;
   localparam logic [4:0] OPC_FNMSUB = 5'b10010;
   localparam logic [4:0] OPC_FNMADD = 5'b10011;

   // Issue-stage state encoding
   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE  = 3'd1;
   localparam logic [2:0] ST_WAIT   = 3'd2;
   localparam logic [2:0] ST_WB_FP  = 3'd3;
   localparam logic [2:0] ST_WB_INT = 3'd4;

   // Ops whose result retires to the integer register file
   function automatic logic is_int_dest(input logic [4:0] opc, input logic [4:0] f5);
      return (opc == OPC_OPFP) &&
             ((f5 == F5_FCMP) || (f5 == F5_FCVTWS) || (f5 == F5_FMVXW));
   endfunction

   // Ops whose first operand comes from the integer rs1 value
   function automatic logic is_int_src(input logic [4:0] opc, input logic [4:0] f5);
      return (opc == OPC_OPFP) && ((f5 == F5_FMVWX) || (f5 == F5_FCVTSW));
   endfunction

endpackage
`default_nettype wire

// File: rtl/fp_regfile.sv
`default_nettype none
// ============================================================================
//  Module      : fp_regfile
//  Description : FP register file, four combinational read ports, two write
//                ports (FLW has priority over writeback), write-through reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module fp_regfile #(
   parameter int NREGS = 32,
   parameter int XLEN  = 32,
   localparam int AW   = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic [3:0][AW-1:0]       rd_addr,
   output logic [3:0][XLEN-1:0]     rd_data,
   input  logic                     flw_we,
   input  logic [AW-1:0]            flw_addr,
   input  logic [XLEN-1:0]          flw_data,
   input  logic                     wb_we,
   input  logic [AW-1:0]            wb_addr,
   input  logic [XLEN-1:0]          wb_data
);

   logic [XLEN-1:0] r_mem [NREGS];

   // Storage update; a same-address collision keeps the FLW data
   always_ff @(posedge clk) begin
      if (flw_we) begin
         r_mem[flw_addr] <= flw_data;
      end
      if (wb_we && !(flw_we && (flw_addr == wb_addr))) begin
         r_mem[wb_addr] <= wb_data;
      end
   end

   // Each read port forwards a same-cycle write so readers never see stale data
   for (genvar gi = 0; gi < 4; gi++) begin : g_rd_port
      assign rd_data[gi] = (flw_we && (flw_addr == rd_addr[gi])) ? flw_data :
                           (wb_we  && (wb_addr  == rd_addr[gi])) ? wb_data  :
                           r_mem[rd_addr[gi]];
   end

endmodule
`default_nettype wire

// File: rtl/fpu_issue.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_issue
//  Description : Blocking issue/writeback stage in front of the FPU. Reads
//                operands, pulses the FPU start, waits for completion and
//                retires to the FP regfile or the integer writeback port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_issue #(
   parameter int NREGS = 32,
   parameter int XLEN  = 32
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            in_valid_i,
   output logic            in_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] intRs1_i,
   output logic            fpuEnable_o,
   output logic [31:0]     fpuInstr_o,
   output logic [XLEN-1:0] fpuRs1_o,
   output logic [XLEN-1:0] fpuRs2_o,
   output logic [XLEN-1:0] fpuRs3_o,
   input  logic            fpuBusy_i,
   input  logic [XLEN-1:0] fpuResult_i,
   output logic            intWb_valid_o,
   input  logic            intWb_ready_i,
   output logic [4:0]      intWb_rd_o,
   output logic [XLEN-1:0] intWb_data_o,
   input  logic            flw_valid_i,
   input  logic [4:0]      flw_rd_i,
   input  logic [XLEN-1:0] flw_data_i,
   input  logic [4:0]      fsw_addr_i,
   output logic [XLEN-1:0] fsw_data_o
);
   import fpu_pkg::*;

   localparam int AW = $clog2(NREGS);

   logic [2:0]            r_state;
   logic [31:0]           r_instr;
   logic [XLEN-1:0]       r_rs1;
   logic [XLEN-1:0]       r_rs2;
   logic [XLEN-1:0]       r_rs3;
   logic [XLEN-1:0]       r_result;

   logic [3:0][AW-1:0]    w_rd_addr;
   logic [3:0][XLEN-1:0]  w_rd_data;
   logic                  w_wb_we;
   logic                  w_int_src;
   logic                  w_int_dest;

   // Operands are read straight from the decode word; rs3 lives in funct5 bits
   assign w_rd_addr[0] = AW'(instr_i[19:15]);
   assign w_rd_addr[1] = AW'(instr_i[24:20]);
   assign w_rd_addr[2] = AW'(instr_i[31:27]);
   assign w_rd_addr[3] = AW'(fsw_addr_i);

   assign w_int_src  = is_int_src(instr_i[6:2], instr_i[31:27]);
   assign w_int_dest = is_int_dest(r_instr[6:2], r_instr[31:27]);

   // A concurrent FLW owns the write ports, so the FP writeback waits it out
   assign w_wb_we = (r_state == ST_WB_FP) && !flw_valid_i;

   fp_regfile #(
      .NREGS (NREGS),
      .XLEN  (XLEN)
   ) u_regfile (
      .clk      (clk_i),
      .rd_addr  (w_rd_addr),
      .rd_data  (w_rd_data),
      .flw_we   (flw_valid_i),
      .flw_addr (AW'(flw_rd_i)),
      .flw_data (flw_data_i),
      .wb_we    (w_wb_we),
      .wb_addr  (AW'(r_instr[11:7])),
      .wb_data  (r_result)
   );

   // Single-op FSM: accept, pulse start, wait for FPU idle, retire
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         r_state  <= ST_IDLE;
         r_instr  <= '0;
         r_rs1    <= '0;
         r_rs2    <= '0;
         r_rs3    <= '0;
         r_result <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (in_valid_i) begin
                  r_instr <= instr_i;
                  r_rs1   <= w_int_src ? intRs1_i : w_rd_data[0];
                  r_rs2   <= w_rd_data[1];
                  r_rs3   <= w_rd_data[2];
                  r_state <= ST_ISSUE;
               end
            end
            ST_ISSUE: r_state <= ST_WAIT;
            ST_WAIT: begin
               if (!fpuBusy_i) begin
                  r_result <= fpuResult_i;
                  r_state  <= w_int_dest ? ST_WB_INT : ST_WB_FP;
               end
            end
            ST_WB_FP: begin
               if (!flw_valid_i) begin
                  r_state <= ST_IDLE;
               end
            end
            ST_WB_INT: begin
               if (intWb_ready_i) begin
                  r_state <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign in_ready_o    = (r_state == ST_IDLE);
   assign fpuEnable_o   = (r_state == ST_ISSUE);
   assign fpuInstr_o    = r_instr;
   assign fpuRs1_o      = r_rs1;
   assign fpuRs2_o      = r_rs2;
   assign fpuRs3_o      = r_rs3;
   assign intWb_valid_o = (r_state == ST_WB_INT);
   assign intWb_rd_o    = r_instr[11:7];
   assign intWb_data_o  = r_result;
   assign fsw_data_o    = w_rd_data[3];

endmodule
`default_nettype wire
